// File: rtl/bin_to_bcd_dabble.sv
// 16-bit binary to 4-digit BCD converter using the sequential shift-add-3 (double dabble)
// algorithm, one input bit per clock, with optional clamping of values above 9999.
module bin_to_bcd_dabble #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] numero,
  output logic [3:0]  miles,
  output logic [3:0]  centenas,
  output logic [3:0]  decenas,
  output logic [3:0]  unidades,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [19:0] scratch_q, scratch_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [19:0] adj;
  logic        ovf_now;

  // Every scratch digit >= 5 gets +3 so the following shift carries correctly into the next digit.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign ovf_now = |scratch_q[19:16];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = numero;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        if (cnt_q == 5'd16) begin
          ovf_d    = ovf_now;
          digits_d = (ovf_now && SATURATE) ? 16'h9999 : scratch_q[15:0];
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          {scratch_d, shift_d} = {adj, shift_q} << 1;
          cnt_d                = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign miles     = digits_q[15:12];
  assign centenas  = digits_q[11:8];
  assign decenas   = digits_q[7:4];
  assign unidades  = digits_q[3:0];
  assign overflow  = ovf_q;
  assign done      = done_q;
  assign busy      = (state_q == CONV);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_dabble.sv
// Bench for bin_to_bcd_dabble: a saturating and a modulo instance share stimulus; each has its
// own expected queue filled at start time and drained when its done pulse appears.
module tb_bin_to_bcd_dabble;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] numero;

  logic [3:0] miles_s, centenas_s, decenas_s, unidades_s;
  logic       busy_s, done_s, overflow_s, dbg_s;
  logic [3:0] miles_m, centenas_m, decenas_m, unidades_m;
  logic       busy_m, done_m, overflow_m, dbg_m;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [16:0] exp_s_q[$];
  logic [16:0] exp_m_q[$];

  bin_to_bcd_dabble #(.SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .numero(numero),
    .miles(miles_s), .centenas(centenas_s), .decenas(decenas_s), .unidades(unidades_s),
    .busy(busy_s), .done(done_s), .overflow(overflow_s), .dbg_state(dbg_s)
  );

  bin_to_bcd_dabble #(.SATURATE(1'b0)) dut_mod (
    .clock(clock), .reset(reset), .start(start), .numero(numero),
    .miles(miles_m), .centenas(centenas_m), .decenas(decenas_m), .unidades(unidades_m),
    .busy(busy_m), .done(done_m), .overflow(overflow_m), .dbg_state(dbg_m)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: {overflow, thousands, hundreds, tens, units}
  function automatic logic [16:0] model(input int v, input bit sat);
    int          m;
    logic [15:0] d;
    m = v % 10000;
    d = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    if (v > 9999 && sat) d = 16'h9999;
    return {(v > 9999), d};
  endfunction

  // ---------------- scoreboards ----------------
  always @(negedge clock) begin
    logic [16:0] e, got;
    if (done_s) begin
      got = {overflow_s, miles_s, centenas_s, decenas_s, unidades_s};
      n_checks++;
      if (exp_s_q.size() == 0) begin
        n_fail++;
        $display("FAIL sat_unexpected_done got=%h required=none", got);
      end else begin
        e = exp_s_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL sat_result got=%h required=%h", got, e);
        end
      end
      n_checks++;
      if (miles_s > 9 || centenas_s > 9 || decenas_s > 9 || unidades_s > 9) begin
        n_fail++;
        $display("FAIL sat_digit_range got=%h required=all<=9", got[15:0]);
      end
    end
  end

  always @(negedge clock) begin
    logic [16:0] e, got;
    if (done_m) begin
      got = {overflow_m, miles_m, centenas_m, decenas_m, unidades_m};
      n_checks++;
      if (exp_m_q.size() == 0) begin
        n_fail++;
        $display("FAIL mod_unexpected_done got=%h required=none", got);
      end else begin
        e = exp_m_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL mod_result got=%h required=%h", got, e);
        end
      end
      n_checks++;
      if (miles_m > 9 || centenas_m > 9 || decenas_m > 9 || unidades_m > 9) begin
        n_fail++;
        $display("FAIL mod_digit_range got=%h required=all<=9", got[15:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the acceptance edge, k = that edge's number.
  task automatic pulse_start(input logic [15:0] v, output int k);
    start  = 1'b1;
    numero = v;
    exp_s_q.push_back(model(int'(v), 1'b1));
    exp_m_q.push_back(model(int'(v), 1'b0));
    @(negedge clock);
    start = 1'b0;
    k     = cyc;
  endtask

  task automatic wait_done(input int max_cyc, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (done_s) begin
        done_cyc = cyc;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    numero = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if ({miles_s, centenas_s, decenas_s, unidades_s, busy_s, done_s, overflow_s} !== 19'd0 ||
        {miles_m, centenas_m, decenas_m, unidades_m, busy_m, done_m, overflow_m} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%h/%h required=0",
               {miles_s, centenas_s, decenas_s, unidades_s, busy_s, done_s, overflow_s},
               {miles_m, centenas_m, decenas_m, unidades_m, busy_m, done_m, overflow_m});
    end
  endtask

  task automatic test_basic();
    int k, busy_cnt, done_cyc;
    pulse_start(16'd1234, k);
    busy_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (done_s) begin
        done_cyc = cyc;
        break;
      end
      if (busy_s) busy_cnt++;
      @(negedge clock);
    end
    n_checks++;
    if (done_cyc !== k + 17) begin
      n_fail++;
      $display("FAIL basic_latency got=%0d required=%0d", done_cyc - k, 17);
    end
    n_checks++;
    if (busy_cnt !== 17) begin
      n_fail++;
      $display("FAIL basic_busy_cycles got=%0d required=17", busy_cnt);
    end
    n_checks++;
    if ({miles_s, centenas_s, decenas_s, unidades_s, overflow_s} !== {16'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_digits got=%h%h%h%h ovf=%b required=1234 ovf=0",
               miles_s, centenas_s, decenas_s, unidades_s, overflow_s);
    end
  endtask

  task automatic test_back_to_back();
    int k, d1, d2;
    pulse_start(16'd0, k);
    wait_done(40, d1);
    // Second start issued while done is high
    pulse_start(16'd9999, k);
    wait_done(40, d2);
    n_checks++;
    if (d1 < 0 || d2 - d1 !== 18) begin
      n_fail++;
      $display("FAIL back_to_back_spacing got=%0d required=18", d2 - d1);
    end
    n_checks++;
    if ({miles_s, centenas_s, decenas_s, unidades_s} !== 16'h9999) begin
      n_fail++;
      $display("FAIL back_to_back_digits got=%h%h%h%h required=9999",
               miles_s, centenas_s, decenas_s, unidades_s);
    end
  endtask

  task automatic test_overflow();
    int k, d;
    pulse_start(16'd65535, k);
    wait_done(40, d);
    n_checks++;
    if ({overflow_s, miles_s, centenas_s, decenas_s, unidades_s} !== {1'b1, 16'h9999}) begin
      n_fail++;
      $display("FAIL ovf_saturate got=%b %h%h%h%h required=1 9999",
               overflow_s, miles_s, centenas_s, decenas_s, unidades_s);
    end
    pulse_start(16'd10007, k);
    wait_done(40, d);
    n_checks++;
    if ({overflow_m, miles_m, centenas_m, decenas_m, unidades_m} !== {1'b1, 16'h0007}) begin
      n_fail++;
      $display("FAIL ovf_modulo got=%b %h%h%h%h required=1 0007",
               overflow_m, miles_m, centenas_m, decenas_m, unidades_m);
    end
    // Boundary pair around 10000
    pulse_start(16'd10000, k);
    wait_done(40, d);
    pulse_start(16'd9999, k);
    wait_done(40, d);
    n_checks++;
    if (overflow_s !== 1'b0 || overflow_m !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_9999 got=%b/%b required=0/0", overflow_s, overflow_m);
    end
  endtask

  task automatic test_ignore_start();
    int k, ndone, dcyc;
    pulse_start(16'd500, k);
    while (cyc < k + 4) @(negedge clock);
    start  = 1'b1;
    numero = 16'd42;
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    dcyc  = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done_s) begin
        ndone++;
        dcyc = cyc;
      end
    end
    n_checks++;
    if (ndone !== 1 || dcyc !== k + 17) begin
      n_fail++;
      $display("FAIL ignore_start got=%0d dones at +%0d required=1 at +17", ndone, dcyc - k);
    end
  endtask

  task automatic test_reset_abort();
    int k, ndone, d;
    pulse_start(16'd4321, k);
    while (cyc < k + 7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_s_q.delete();
    exp_m_q.delete();
    n_checks++;
    if ({miles_s, centenas_s, decenas_s, unidades_s, busy_s, done_s, overflow_s} !== 19'd0) begin
      n_fail++;
      $display("FAIL abort_outputs got=%h required=0",
               {miles_s, centenas_s, decenas_s, unidades_s, busy_s, done_s, overflow_s});
    end
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (done_s) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done got=%0d required=0", ndone);
    end
    pulse_start(16'd4321, k);
    wait_done(40, d);
    n_checks++;
    if (d !== k + 17) begin
      n_fail++;
      $display("FAIL abort_restart got=%0d required=%0d", d, k + 17);
    end
  endtask

  task automatic test_random();
    int k, d;
    for (int i = 0; i < 40; i++) begin
      pulse_start(16'($urandom_range(0, 65535)), k);
      wait_done(40, d);
      n_checks++;
      if (d !== k + 17) begin
        n_fail++;
        $display("FAIL random_latency got=%0d required=%0d", d - k, 17);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_ignore_start();
    test_reset_abort();
    test_random();
    repeat (2) @(negedge clock);
    n_checks++;
    if (exp_s_q.size() != 0 || exp_m_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected got=%0d/%0d required=0/0", exp_s_q.size(), exp_m_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
